// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick strobes.
// Divisor writes to a running channel are deferred to the end of its period.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] cfg_busy_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic ch_ok;

    assign ch_ok = 32'(cfg_ch_i) < 32'(NUM_CH);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] pnd_q, pnd_d;
        logic [DIV_W-1:0] h;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wrap, sel, apply;

        always_comb begin
            h     = (act_q == '0) ? DIV_W'(1) : act_q;
            wrap  = (cnt_q == h - DIV_W'(1));
            sel   = cfg_we_i && ch_ok && (cfg_ch_i == CH_W'(k));
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (en_i[k]) begin
                if (wrap) begin
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                    clk_d = clk_q;
                end
            end
            // A pending divisor lands at the falling edge, or at once if disabled
            apply  = pend_q && (en_i[k] ? (wrap && clk_q) : 1'b1);
            act_d  = act_q;
            pnd_d  = pnd_q;
            pend_d = pend_q;
            if (apply) begin
                act_d  = pnd_q;
                pend_d = 1'b0;
            end
            if (sel) begin
                if (en_i[k]) begin
                    pnd_d  = cfg_div_i;
                    pend_d = 1'b1;
                end else begin
                    act_d = cfg_div_i;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                act_q  <= DIV_W'(DEFAULT_DIV);
                pnd_q  <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                pnd_q  <= pnd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_o[k]      = clk_q;
        assign tick_o[k]     = tick_q;
        assign cfg_busy_o[k] = pend_q;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Programmable multi-channel clock divider. It generates `NUM_CH` independent divided clocks from one system clock, each with a runtime-writable divisor. Each channel also produces a single-cycle tick on every rising edge of its divided clock. Divisor changes take effect glitch-free at period boundaries. The block sits beside the core and peripherals, supplying slow strobes and clocks (UART baud, timers, LED/debug clocks).

## Interface
- `NUM_CH`, default 4: number of independent channels (≥1).
- `DIV_W`, default 16: divisor width in bits.
- `DEFAULT_DIV`, default 50: half-period divisor loaded into every channel at reset (1 ≤ value < 2^DIV_W).
- `CH_W`, localparam = max(1, $clog2(NUM_CH)): channel-select width.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `en_i`  in  NUM_CH  per-channel enable.
- `cfg_we_i`  in  1  divisor write strobe, one cycle per write.
- `cfg_ch_i`  in  CH_W  target channel of the write.
- `cfg_div_i`  in  DIV_W  new half-period divisor H.
- `cfg_busy_o`  out  NUM_CH  a written divisor is pending on that channel.
- `clk_o`  out  NUM_CH  divided clock, period 2·H input cycles, 50 % duty.
- `tick_o`  out  NUM_CH  one-cycle pulse in the first cycle `clk_o` is high.

## Operation
- Per channel state:
  - `cnt` (DIV_W bits)
  - `div_act` (active H)
  - `div_pend` (pending H)
  - `pend` flag
  - `clk_o` register
  - `tick_o` register
- Effective H = `div_act`, with 0 treated as 1. All compares use DIV_W-bit unsigned arithmetic. No wider intermediates are needed.
- Enabled channel, each cycle:
  - If `cnt == H-1`: `cnt <= 0` and `clk_o` toggles. `tick_o <= 1` iff `clk_o` goes 0→1.
  - Otherwise: `cnt <= cnt+1`, `tick_o <= 0`.
- Disabled channel (`en_i[k]=0`):
  - `cnt <= 0`, `clk_o <= 0`, `tick_o <= 0` on the next edge.
  - Re-enabling starts a fresh period: first rise after H cycles.
- Write (`cfg_we_i=1`, `cfg_ch_i < NUM_CH`):
  - Channel disabled: `div_act <= cfg_div_i` directly. `pend` stays 0.
  - Channel enabled: `div_pend <= cfg_div_i` and `pend <= 1`.
- Pending apply: on the edge where an enabled channel's `clk_o` toggles 1→0 (end of full period):
  - `div_act <= div_pend`, `pend <= 0`.
  - The next period uses the new H. The current period is never truncated or stretched.
- A write to a channel with `pend=1` overwrites `div_pend` (last write wins). If it lands in the same cycle as the apply, the new value becomes pending and `pend` stays 1.
- A channel disabled while `pend=1` applies `div_pend` on that edge and clears `pend`.
- Writes with `cfg_ch_i ≥ NUM_CH` are ignored.
- `cfg_busy_o[k] = pend[k]`.
- Channels are fully independent; one write affects only the addressed channel.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values (asynchronous, immediate on `rst_ni` low):
  - `clk_o = 0`, `tick_o = 0`, `cfg_busy_o = 0`.
  - `cnt = 0`, `div_act = DEFAULT_DIV`.
- Release is sampled at `clk_i` posedge; no output changes until H enabled edges have elapsed.
- From the first enabled edge (cnt=0), `clk_o` rises after the H-th edge. It falls H edges later. `tick_o` is high exactly in the cycle `clk_o` first reads 1.
- H=1 (or 0): `clk_o` toggles every edge (clk_i/2), and `tick_o` is high every other cycle.
- Write-to-busy latency is 1 cycle. Busy clears on the same edge that `clk_o` falls.
- Reset asserted mid-period: all channels return to the reset values immediately, and pending divisors are discarded.

## Test plan
- **Reset/default:** `DEFAULT_DIV=3`, all `en_i=1`, release reset → `clk_o` low 3 cycles, high 3, period 6; `tick_o` one pulse per 6 cycles aligned to `clk_o` rise; all outputs 0 during reset.
- **Runtime change:** ch0 H=4, write H=2 while `clk_o` high at cnt=1 → `cfg_busy_o[0]=1` next cycle; the current high phase still lasts 4 cycles; busy clears at the fall; the following low/high phases are 2 cycles each.
- **Disabled write + overwrite:**
  - Write H=5 to a disabled channel → busy never asserts; after enable, first rise after 5 cycles.
  - Two writes H=7 then H=9 to an enabled channel → period after apply is 18.
- **Edge divisors and invalid index:**
  - H=0 and H=1 → clk_i/2 output.
  - H=2^DIV_W−1 → no counter overflow, half-period 65535 for DIV_W=16.
  - Write with `cfg_ch_i=NUM_CH` (NUM_CH=3) → no channel changes.
- **Enable toggling:** drop `en_i[1]` mid-high → `clk_o[1]=0` next cycle, no tick; re-enable → rise after exactly H cycles; other channels unaffected.
- **Async reset mid-operation:** assert `rst_ni` between clock edges with a pending write → outputs 0 immediately; after release, the divisor is `DEFAULT_DIV` and busy is 0.
